// File: rtl/line_buffer_window_pkg.sv
// Shared types and helpers for the 3x3 sliding-window generator.
package line_buffer_window_pkg;

   localparam int PIXEL_W = 8;

   typedef logic [PIXEL_W-1:0] pix_t;

   // Window slot order, row-major: P1 top-left, P5 centre, P9 bottom-right.
   typedef enum logic [3:0] {P1, P2, P3, P4, P5, P6, P7, P8, P9} win_idx_e;

   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_window_ram.sv
// One-line pixel store: single port, asynchronous read, so the old entry is
// seen in the same cycle that it is overwritten.
module line_buffer_ram
   import line_buffer_window_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  pix_t          wdata,
   output pix_t          rdata
);

   pix_t mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= wdata;
   end

endmodule

// File: rtl/line_buffer_window.sv
// Raster-order pixel stream in, one registered 3x3 window per accepted pixel
// once two full lines and two columns of the current frame are available.
module line_buffer_window
   import line_buffer_window_pkg::*;
#(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_sof,
   input  logic [PIXEL_W-1:0] in_pixel,
   output logic               out_valid,
   output logic               out_eof,
   output logic [PIXEL_W-1:0] window_p1,
   output logic [PIXEL_W-1:0] window_p2,
   output logic [PIXEL_W-1:0] window_p3,
   output logic [PIXEL_W-1:0] window_p4,
   output logic [PIXEL_W-1:0] window_p5,
   output logic [PIXEL_W-1:0] window_p6,
   output logic [PIXEL_W-1:0] window_p7,
   output logic [PIXEL_W-1:0] window_p8,
   output logic [PIXEL_W-1:0] window_p9
);

   localparam int CW = cnt_w(IMG_WIDTH);
   localparam int RW = cnt_w(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col, c_eff;
   logic [RW-1:0] row, r_eff;
   pix_t          top, mid;
   pix_t [1:0]    sh_t, sh_m, sh_b;   // [0] = column c-1, [1] = column c-2
   pix_t [8:0]    win_q;

   // A start-of-frame pixel is (0,0) whatever the counters say.
   assign c_eff = in_sof ? '0 : col;
   assign r_eff = in_sof ? '0 : row;

   // lb_prev holds row r-1; on write its old entry cascades into lb_prev2.
   line_buffer_ram #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_prev (
      .clk   (clk),
      .en    (in_valid),
      .addr  (c_eff),
      .wdata (in_pixel),
      .rdata (mid)
   );

   line_buffer_ram #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb_prev2 (
      .clk   (clk),
      .en    (in_valid),
      .addr  (c_eff),
      .wdata (mid),
      .rdata (top)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         sh_t      <= '0;
         sh_m      <= '0;
         sh_b      <= '0;
         win_q     <= '0;
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         if (in_valid) begin
            if (c_eff == COL_LAST) begin
               col <= '0;
               row <= (r_eff == ROW_LAST) ? '0 : r_eff + 1'b1;
            end else begin
               col <= c_eff + 1'b1;
               row <= r_eff;
            end
            sh_t <= {sh_t[0], top};
            sh_m <= {sh_m[0], mid};
            sh_b <= {sh_b[0], in_pixel};
            // Columns left over from the previous line only sit in the shift
            // registers while c < 2, when nothing is emitted.
            if (r_eff >= RW'(2) && c_eff >= CW'(2)) begin
               out_valid <= 1'b1;
               out_eof   <= (r_eff == ROW_LAST) && (c_eff == COL_LAST);
               win_q[P1] <= sh_t[1];
               win_q[P2] <= sh_t[0];
               win_q[P3] <= top;
               win_q[P4] <= sh_m[1];
               win_q[P5] <= sh_m[0];
               win_q[P6] <= mid;
               win_q[P7] <= sh_b[1];
               win_q[P8] <= sh_b[0];
               win_q[P9] <= in_pixel;
            end
         end
      end
   end

   assign window_p1 = win_q[P1];
   assign window_p2 = win_q[P2];
   assign window_p3 = win_q[P3];
   assign window_p4 = win_q[P4];
   assign window_p5 = win_q[P5];
   assign window_p6 = win_q[P6];
   assign window_p7 = win_q[P7];
   assign window_p8 = win_q[P8];
   assign window_p9 = win_q[P9];

endmodule

// File: tb/tb_line_buffer_window.sv
// Scoreboard bench: a frame-array model pushes expected windows, a negedge
// monitor pops and compares whatever the DUT emits.
module tb_line_buffer_window;

   localparam int W = 5;
   localparam int H = 4;

   typedef struct {
      logic [71:0] win;
      logic        eof;
   } exp_t;

   logic       clk, rst_n, in_valid, in_sof;
   logic [7:0] in_pixel;
   logic       out_valid, out_eof;
   logic [7:0] window_p1, window_p2, window_p3, window_p4, window_p5;
   logic [7:0] window_p6, window_p7, window_p8, window_p9;

   line_buffer_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_eof   (out_eof),
      .window_p1 (window_p1),
      .window_p2 (window_p2),
      .window_p3 (window_p3),
      .window_p4 (window_p4),
      .window_p5 (window_p5),
      .window_p6 (window_p6),
      .window_p7 (window_p7),
      .window_p8 (window_p8),
      .window_p9 (window_p9)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];
   int   img [H][W];
   int   mr = 0, mc = 0;
   int   win_exp = 0, win_seen = 0, eof_exp = 0, eof_seen = 0;
   logic [71:0] last_win = '0;

   wire [71:0] win_act = {window_p1, window_p2, window_p3, window_p4, window_p5,
                          window_p6, window_p7, window_p8, window_p9};

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: the frame is an array indexed by (row, col); a window is just
   // the 3x3 block ending at the pixel just accepted.
   task automatic model_accept(input int pix, input bit sof);
      exp_t e;
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
         e.win = '0;
         for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
               e.win = {e.win[63:0], 8'(img[mr-2+dr][mc-2+dc])};
         e.eof = (mr == H-1 && mc == W-1);
         q.push_back(e);
         win_exp++;
         if (e.eof) eof_exp++;
      end
      mc++;
      if (mc == W) begin
         mc = 0;
         mr = (mr == H-1) ? 0 : mr + 1;
      end
   endtask

   task automatic drive(input bit v, input bit s, input int p);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
      in_pixel = 8'(p);
      if (v) model_accept(p, s);
   endtask

   // mode 0: continuous, 1: idle after every pixel, 2: random idles
   task automatic send_frame(input int base, input bit sof, input int mode, input bit rnd);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            drive(1'b1, sof && r == 0 && c == 0,
                  rnd ? int'($urandom_range(0, 255)) : base + 10*r + c);
            if (mode == 1) drive(1'b0, 1'b0, 0);
            if (mode == 2)
               while ($urandom_range(0, 2) == 0)
                  drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
         end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_valid", {71'b0, out_valid}, 72'b0);
         chk("reset_window", win_act, 72'b0);
         last_win <= '0;
      end else if (out_valid) begin
         win_seen++;
         if (out_eof) eof_seen++;
         if (q.size() == 0) begin
            chk("unexpected_valid", {71'b0, out_valid}, 72'b0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("window", win_act, e.win);
            chk("eof", {71'b0, out_eof}, {71'b0, e.eof});
            last_win <= e.win;
         end
      end else begin
         chk("hold_window", win_act, last_win);
         chk("eof_idle", {71'b0, out_eof}, 72'b0);
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      send_frame(0, 1'b1, 0, 1'b0);           // 10r+c, continuous
      send_frame(0, 1'b1, 1, 1'b0);           // same image, toggling valid
      send_frame(0, 1'b1, 0, 1'b0);           // back-to-back pair
      send_frame(100, 1'b1, 0, 1'b0);
      drive(1'b0, 1'b0, 0);

      // Abandon a frame at (1,3) with a new start of frame.
      for (int i = 0; i < W + 3; i++) drive(1'b1, i == 0, 50 + i);
      send_frame(0, 1'b1, 0, 1'b0);
      drive(1'b0, 1'b0, 0);

      // Asynchronous reset after pixel (2,3).
      for (int i = 0; i < 2*W + 4; i++) drive(1'b1, i == 0, 10*(i / W) + (i % W));
      drive(1'b0, 1'b0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", {71'b0, out_valid}, 72'b0);
      chk("async_reset_window", win_act, 72'b0);
      mr = 0; mc = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      send_frame(0, 1'b0, 0, 1'b0);           // no sof after reset

      // Random content, random gaps, frames chained by counter wrap.
      for (int f = 0; f < 6; f++) send_frame(0, f == 0, 2, 1'b1);
      // Random mid-frame restarts.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < int'($urandom_range(1, W*H - 1)); i++)
            drive(1'b1, 1'b0, int'($urandom_range(0, 255)));
         send_frame(0, 1'b1, 2, 1'b1);
      end

      repeat (4) drive(1'b0, 1'b0, 0);
      chk("queue_drained", 72'(q.size()), 72'd0);
      chk("window_count", 72'(win_seen), 72'(win_exp));
      chk("eof_count", 72'(eof_seen), 72'(eof_exp));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
